// File: rtl/decodificador_display_7segmentos_pkg.sv
`default_nettype none
// ============================================================================
// Module   : decodificador_display_7segmentos_pkg
// Purpose  : Segment table, idle/blank bus levels and counter sizing helper
// Revision : 1.0 - initial release
// ============================================================================
package decodificador_display_7segmentos_pkg;

  localparam logic [6:0] c_seg_apagado  = 7'b1111111;
  localparam logic [3:0] c_anodo_blanco = 4'b1111;

  // Active-low {g,f,e,d,c,b,a}, indexed by the hex value it displays
  localparam logic [6:0] c_tabla_segmentos [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  function automatic int ancho_contador(input int max_valor);
    return (max_valor < 2) ? 1 : $clog2(max_valor + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/decodificador_display_7segmentos_hex.sv
`default_nettype none
// ============================================================================
// Module   : decodificador_segmentos_hex
// Purpose  : Active-low 7-segment pattern to hex nibble, with a valid flag
// Revision : 1.0 - initial release
// ============================================================================
module decodificador_segmentos_hex
  import decodificador_display_7segmentos_pkg::*;
(
  input  logic [6:0] i_segmentos,
  output logic [3:0] o_nibble,
  output logic       o_valido
);

  always_comb begin
    o_nibble = '0;
    o_valido = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i_segmentos == c_tabla_segmentos[i]) begin
        o_nibble = 4'(i);
        o_valido = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/decodificador_display_7segmentos.sv
`default_nettype none
// ============================================================================
// Module   : decodificador_display_7segmentos
// Purpose  : Recovers the four hex digits from a multiplexed 7-segment bus
// Revision : 1.0 - initial release
// ============================================================================
module decodificador_display_7segmentos
  import decodificador_display_7segmentos_pkg::*;
#(
  parameter int P_ESTABLE = 4,
  parameter int P_TIMEOUT = 1024
) (
  input  logic       i_Reloj,
  input  logic       i_Reset,
  input  logic [6:0] i_Segmentos,
  input  logic [3:0] i_Anodo_4_Bits,
  output logic [3:0] o_Datos_0,
  output logic [3:0] o_Datos_1,
  output logic [3:0] o_Datos_2,
  output logic [3:0] o_Datos_3,
  output logic       o_Trama_Valida,
  output logic [3:0] o_Digitos_Vistos,
  output logic       o_Error_Segmento,
  output logic       o_Error_Anodo,
  output logic       o_Activo
);

  localparam int c_ancho_est = ancho_contador(P_ESTABLE);
  localparam int c_ancho_to  = ancho_contador(P_TIMEOUT);
  localparam logic [c_ancho_est-1:0] c_est_max    = c_ancho_est'(P_ESTABLE);
  localparam logic [c_ancho_est-1:0] c_est_acepta = c_ancho_est'(P_ESTABLE - 1);
  localparam logic [c_ancho_to-1:0]  c_to_max     = c_ancho_to'(P_TIMEOUT);
  localparam logic [c_ancho_to-1:0]  c_to_ultimo  = c_ancho_to'(P_TIMEOUT - 1);

  logic [6:0]             r_seg_s1, r_seg_s2;
  logic [3:0]             r_an_s1, r_an_s2;
  logic [10:0]            r_vec_prev;
  logic [c_ancho_est-1:0] r_cnt_est;
  logic [c_ancho_to-1:0]  r_cnt_to;
  logic [3:0]             r_sombra [4];
  logic [3:0]             r_datos  [4];
  logic [3:0]             r_vistos;
  logic                   r_trama, r_err_seg, r_err_an, r_activo;

  logic [10:0] w_vec;
  logic [3:0]  w_an_acep, w_nibble, w_vistos_sig;
  logic [1:0]  w_indice;
  logic        w_valido, w_acepta, w_un_bajo, w_varios;
  logic        w_digito_valido, w_timeout_llega;

  assign w_vec     = {r_an_s2, r_seg_s2};
  // r_vec_prev holds the vector that has been stable for r_cnt_est cycles
  assign w_an_acep = r_vec_prev[10:7];
  assign w_acepta  = (r_cnt_est == c_est_acepta);
  assign w_un_bajo = $onehot(~w_an_acep);
  assign w_varios  = (w_an_acep != c_anodo_blanco) && !w_un_bajo;

  decodificador_segmentos_hex u_hex (
    .i_segmentos (r_vec_prev[6:0]),
    .o_nibble    (w_nibble),
    .o_valido    (w_valido)
  );

  always_comb begin
    w_indice = '0;
    for (int k = 0; k < 4; k++) begin
      if (!w_an_acep[k]) w_indice = 2'(k);
    end
  end

  assign w_digito_valido = w_acepta && w_un_bajo && w_valido;
  assign w_timeout_llega = !w_digito_valido && (r_cnt_to == c_to_ultimo);

  // A digit set in the publication cycle survives the clear
  always_comb begin
    w_vistos_sig = r_vistos;
    if ((r_vistos == 4'b1111) || w_timeout_llega) w_vistos_sig = '0;
    if (w_digito_valido) w_vistos_sig[w_indice] = 1'b1;
  end

  always_ff @(posedge i_Reloj or negedge i_Reset) begin
    if (!i_Reset) begin
      r_seg_s1   <= c_seg_apagado;
      r_seg_s2   <= c_seg_apagado;
      r_an_s1    <= c_anodo_blanco;
      r_an_s2    <= c_anodo_blanco;
      r_vec_prev <= {c_anodo_blanco, c_seg_apagado};
      r_cnt_est  <= '0;
      r_cnt_to   <= '0;
      r_vistos   <= '0;
      r_trama    <= 1'b0;
      r_err_seg  <= 1'b0;
      r_err_an   <= 1'b0;
      r_activo   <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        r_sombra[k] <= '0;
        r_datos[k]  <= '0;
      end
    end else begin
      r_seg_s1   <= i_Segmentos;
      r_seg_s2   <= r_seg_s1;
      r_an_s1    <= i_Anodo_4_Bits;
      r_an_s2    <= r_an_s1;
      r_vec_prev <= w_vec;

      if (w_vec != r_vec_prev)    r_cnt_est <= '0;
      else if (r_cnt_est != c_est_max) r_cnt_est <= r_cnt_est + 1'b1;

      if (w_digito_valido)        r_cnt_to <= '0;
      else if (r_cnt_to != c_to_max) r_cnt_to <= r_cnt_to + 1'b1;

      if (w_digito_valido)      r_activo <= 1'b1;
      else if (w_timeout_llega) r_activo <= 1'b0;

      if (w_digito_valido) r_sombra[w_indice] <= w_nibble;

      r_err_seg <= w_acepta && w_un_bajo && !w_valido;
      r_err_an  <= w_acepta && w_varios;

      r_trama <= (r_vistos == 4'b1111);
      if (r_vistos == 4'b1111) begin
        for (int k = 0; k < 4; k++) r_datos[k] <= r_sombra[k];
      end
      r_vistos <= w_vistos_sig;
    end
  end

  assign o_Datos_0        = r_datos[0];
  assign o_Datos_1        = r_datos[1];
  assign o_Datos_2        = r_datos[2];
  assign o_Datos_3        = r_datos[3];
  assign o_Trama_Valida   = r_trama;
  assign o_Digitos_Vistos = r_vistos;
  assign o_Error_Segmento = r_err_seg;
  assign o_Error_Anodo    = r_err_an;
  assign o_Activo         = r_activo;

endmodule
`default_nettype wire

// File: tb/tb_decodificador_display_7segmentos.sv
`default_nettype none
// ============================================================================
// Module   : tb_decodificador_display_7segmentos
// Purpose  : Self-checking bench: vector table, frame scoreboard, corner cases
// Revision : 1.0 - initial release
// ============================================================================
module tb_decodificador_display_7segmentos;

  localparam int P_ESTABLE = 4;
  localparam int P_TIMEOUT = 200;
  localparam int HOLD      = P_ESTABLE + 5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] seg;
  logic [3:0] an;
  logic [3:0] d0, d1, d2, d3, vistos;
  logic       trama, err_seg, err_an, activo;

  always #5 clk = ~clk;

  decodificador_display_7segmentos #(
    .P_ESTABLE (P_ESTABLE),
    .P_TIMEOUT (P_TIMEOUT)
  ) dut (
    .i_Reloj          (clk),
    .i_Reset          (rst_n),
    .i_Segmentos      (seg),
    .i_Anodo_4_Bits   (an),
    .o_Datos_0        (d0),
    .o_Datos_1        (d1),
    .o_Datos_2        (d2),
    .o_Datos_3        (d3),
    .o_Trama_Valida   (trama),
    .o_Digitos_Vistos (vistos),
    .o_Error_Segmento (err_seg),
    .o_Error_Anodo    (err_an),
    .o_Activo         (activo)
  );

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic [3:0] nib;
    logic       e_seg;
    logic       e_an;
  } vec_t;

  vec_t        tabla [18];
  logic [15:0] cola [$];
  int          checks = 0, failures = 0;
  int          n_err_seg = 0, n_err_an = 0, n_tramas = 0;
  logic [3:0]  m_sombra [4];
  logic [3:0]  m_vistos;

  task automatic comparar(input string nombre, input logic [31:0] real_v, input logic [31:0] esp);
    checks++;
    if (real_v !== esp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", nombre, real_v, esp);
    end
  endtask

  // Scoreboard: every published frame must match the oldest expected frame
  always @(negedge clk) begin
    if (err_seg) n_err_seg++;
    if (err_an)  n_err_an++;
    if (trama) begin
      n_tramas++;
      checks++;
      if (cola.size() == 0) begin
        failures++;
        $display("FAIL trama_inesperada: got=%h expected=none", {d3, d2, d1, d0});
      end else begin
        logic [15:0] esp;
        esp = cola.pop_front();
        if ({d3, d2, d1, d0} !== esp) begin
          failures++;
          $display("FAIL trama_datos: got=%h expected=%h", {d3, d2, d1, d0}, esp);
        end
      end
    end
  end

  task automatic conducir(input logic [3:0] a, input logic [6:0] s, input int ciclos);
    an  = a;
    seg = s;
    repeat (ciclos) @(posedge clk);
    #1;
  endtask

  task automatic aplicar(input vec_t v, input string nombre);
    int s0, a0;
    s0 = n_err_seg;
    a0 = n_err_an;
    if (!v.e_seg && !v.e_an && v.an != 4'hF) begin
      for (int k = 0; k < 4; k++) begin
        if (!v.an[k]) begin
          m_sombra[k] = v.nib;
          m_vistos[k] = 1'b1;
        end
      end
      if (m_vistos == 4'hF) begin
        cola.push_back({m_sombra[3], m_sombra[2], m_sombra[1], m_sombra[0]});
        m_vistos = 4'h0;
      end
    end
    conducir(v.an, v.seg, HOLD);
    conducir(4'hF, 7'h7F, HOLD);
    comparar({nombre, " err_seg"}, 32'(n_err_seg - s0), {31'd0, v.e_seg});
    comparar({nombre, " err_an"},  32'(n_err_an - a0),  {31'd0, v.e_an});
    comparar({nombre, " vistos"},  {28'd0, vistos},     {28'd0, m_vistos});
  endtask

  function automatic vec_t dig(input logic [3:0] a, input logic [6:0] s, input logic [3:0] n);
    dig = '{a, s, n, 1'b0, 1'b0};
  endfunction

  initial begin
    tabla[0]  = dig(4'b1110, 7'b1111001, 4'h1);
    tabla[1]  = dig(4'b1101, 7'b0100100, 4'h2);
    tabla[2]  = dig(4'b1011, 7'b0110000, 4'h3);
    tabla[3]  = dig(4'b0111, 7'b0011001, 4'h4);
    tabla[4]  = dig(4'b1101, 7'b0000011, 4'hB);
    tabla[5]  = '{4'b1110, 7'b1111111, 4'h0, 1'b1, 1'b0};
    tabla[6]  = '{4'b1100, 7'b0000000, 4'h0, 1'b0, 1'b1};
    tabla[7]  = dig(4'b1111, 7'b0000000, 4'h0);
    tabla[8]  = dig(4'b1110, 7'b0001000, 4'hA);
    tabla[9]  = dig(4'b1101, 7'b1000110, 4'hC);
    tabla[10] = dig(4'b1011, 7'b0100001, 4'hD);
    tabla[11] = dig(4'b1110, 7'b0000110, 4'hE);
    tabla[12] = dig(4'b0111, 7'b0001110, 4'hF);
    tabla[13] = dig(4'b1110, 7'b1000000, 4'h0);
    tabla[14] = dig(4'b1101, 7'b0010000, 4'h9);
    tabla[15] = dig(4'b1011, 7'b1111000, 4'h7);
    tabla[16] = dig(4'b0111, 7'b0000010, 4'h6);
    tabla[17] = dig(4'b1110, 7'b0010010, 4'h5);
    for (int k = 0; k < 4; k++) m_sombra[k] = 4'h0;
    m_vistos = 4'h0;

    rst_n = 1'b0;
    an    = 4'hF;
    seg   = 7'h7F;
    repeat (3) @(posedge clk);
    @(negedge clk);
    comparar("reset_salidas", {9'd0, d3, d2, d1, d0, vistos, trama, err_seg, err_an, activo}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    conducir(4'hF, 7'h7F, HOLD);

    for (int i = 0; i < 18; i++) aplicar(tabla[i], $sformatf("tabla%0d", i));
    comparar("activo_tras_tabla", {31'd0, activo}, 32'd1);

    // Glitch one cycle shorter than the stability window is ignored
    begin
      int s0, a0;
      s0 = n_err_seg;
      a0 = n_err_an;
      conducir(4'b0111, 7'b0000000, P_ESTABLE - 1);
      conducir(4'hF, 7'h7F, HOLD);
      comparar("glitch vistos", {28'd0, vistos}, {28'd0, m_vistos});
      comparar("glitch errores", 32'((n_err_seg - s0) + (n_err_an - a0)), 32'd0);
    end

    // Three digits then silence: timeout clears the partial frame only
    aplicar(dig(4'b1101, 7'b1111001, 4'h1), "to_d1");
    aplicar(dig(4'b1011, 7'b0100100, 4'h2), "to_d2");
    comparar("to vistos_previo", {28'd0, vistos}, 32'h7);
    repeat (P_TIMEOUT + 10) @(posedge clk);
    #1;
    m_vistos = 4'h0;
    comparar("to activo", {31'd0, activo}, 32'd0);
    comparar("to vistos", {28'd0, vistos}, 32'd0);
    comparar("to datos", {16'd0, d3, d2, d1, d0}, 32'h6790);

    // Reset mid-frame discards the partial frame
    aplicar(dig(4'b1110, 7'b1111001, 4'h1), "rst_d0");
    aplicar(dig(4'b1101, 7'b0100100, 4'h2), "rst_d1");
    aplicar(dig(4'b1011, 7'b0110000, 4'h3), "rst_d2");
    rst_n = 1'b0;
    @(negedge clk);
    comparar("rst_medio_salidas", {9'd0, d3, d2, d1, d0, vistos, trama, err_seg, err_an, activo}, 32'd0);
    m_vistos = 4'h0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    aplicar(dig(4'b1110, 7'b0010010, 4'h5), "post_d0");
    aplicar(dig(4'b1101, 7'b0000010, 4'h6), "post_d1");
    aplicar(dig(4'b1011, 7'b1111000, 4'h7), "post_d2");
    aplicar(dig(4'b0111, 7'b0000000, 4'h8), "post_d3");
    repeat (5) @(posedge clk);
    #1;
    comparar("post datos", {16'd0, d3, d2, d1, d0}, 32'h8765);
    comparar("post activo", {31'd0, activo}, 32'd1);
    comparar("cola_vacia", 32'(cola.size()), 32'd0);
    comparar("num_tramas", 32'(n_tramas), 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
